// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared encodings for the instruction/data memory port arbiter:
//            one-hot FSM state codes and the grant-source enum.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // One-hot arbiter state codes
    localparam int              STATE_W = 3;
    localparam logic [STATE_W-1:0] S_IDLE = 3'b001;
    localparam logic [STATE_W-1:0] S_REQ  = 3'b010;
    localparam logic [STATE_W-1:0] S_RESP = 3'b100;

    // Which requester owns the transaction in flight
    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } grant_src_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/arb_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : arb_rr_picker
// Brief    : Two-way grant picker for the memory port arbiter. Remembers the
//            side granted last; on a conflict either alternates (RR_EN=1) or
//            always favours the data side (RR_EN=0).
// Revision : 1.0 - initial release
// ============================================================================
module arb_rr_picker
    import mem_arb_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_inst_pend,
    input  logic       i_data_pend,
    input  logic       i_take,
    output grant_src_t o_src
);

    grant_src_t r_last;

    // Choose the winner from the pending flags and the last-grant history
    always_comb begin
        o_src = SRC_INST;
        if (i_data_pend && !i_inst_pend) begin
            o_src = SRC_DATA;
        end else if (i_data_pend && i_inst_pend) begin
            if (RR_EN == 0) begin
                o_src = SRC_DATA;
            end else if (r_last == SRC_INST) begin
                o_src = SRC_DATA;
            end else begin
                o_src = SRC_INST;
            end
        end
    end

    // Last-grant flag starts at instruction so data wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= SRC_INST;
        end else if (i_take) begin
            r_last <= o_src;
        end
    end

endmodule : arb_rr_picker
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between the CPU fetch and data channels.
//            One transaction in flight; read data returns to its requester;
//            writes complete on bus acceptance.
//            Optional macro ARB_PERF_CNT_EN builds per-side wait counters.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RR_EN  = 1
) (
    input  logic                clk,
    input  logic                rst,
    // instruction fetch channel
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_rvalid,
    input  logic                i_rready,
    // data channel
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_req_ready,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_rvalid,
    input  logic                d_rready,
    // memory port
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_read,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    input  logic                m_req_ready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_rvalid,
    output logic                m_rready,
    // performance counters
    output logic [31:0]         perf_i_wait,
    output logic [31:0]         perf_d_wait
);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_wstrb;
    grant_src_t          r_src;
    grant_src_t          w_src;
    logic                w_inst_pend;
    logic                w_data_pend;
    logic                w_take;

    assign w_inst_pend = i_req_valid;
    assign w_data_pend = d_read | d_write;
    // A grant is taken only from idle and never while reset is asserted,
    // otherwise the requester would see acceptance of a dropped request.
    assign w_take      = (r_state == S_IDLE) && (w_inst_pend || w_data_pend) && !rst;

    arb_rr_picker #(
        .RR_EN (RR_EN)
    ) u_picker (
        .clk         (clk),
        .rst         (rst),
        .i_inst_pend (w_inst_pend),
        .i_data_pend (w_data_pend),
        .i_take      (w_take),
        .o_src       (w_src)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: idle -> request -> (response for reads) -> idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_inst_pend || w_data_pend) w_state_nxt = S_REQ;
            S_REQ:  if (m_req_ready) w_state_nxt = r_write ? S_IDLE : S_RESP;
            S_RESP: if (m_rvalid && m_rready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the winner's request; d_write dominates an illegal read+write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_src   <= SRC_INST;
        end else if (w_take) begin
            r_src <= w_src;
            if (w_src == SRC_DATA) begin
                r_addr  <= d_addr;
                r_write <= d_write;
                r_wdata <= d_wdata;
                r_wstrb <= d_write ? d_wstrb : '0;
            end else begin
                r_addr  <= i_addr;
                r_write <= 1'b0;
                r_wdata <= '0;
                r_wstrb <= '0;
            end
        end
    end

    // Bus request fields come only from the captured registers
    assign m_addr  = r_addr;
    assign m_wdata = r_wdata;
    assign m_wstrb = r_wstrb;

    // Per-state handshakes and response steering to the granted side
    always_comb begin
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        m_read      = 1'b0;
        m_write     = 1'b0;
        m_rready    = 1'b0;
        i_rvalid    = 1'b0;
        d_rvalid    = 1'b0;
        i_rdata     = '0;
        d_rdata     = '0;
        case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    i_req_ready = w_inst_pend && (w_src == SRC_INST);
                    d_req_ready = w_data_pend && (w_src == SRC_DATA);
                end
            end
            S_REQ: begin
                m_read  = !r_write;
                m_write = r_write;
            end
            S_RESP: begin
                if (r_src == SRC_DATA) begin
                    m_rready = d_rready;
                    d_rvalid = m_rvalid;
                    d_rdata  = m_rdata;
                end else begin
                    m_rready = i_rready;
                    i_rvalid = m_rvalid;
                    i_rdata  = m_rdata;
                end
            end
            default: ;
        endcase
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] r_perf_i_wait;
    logic [31:0] r_perf_d_wait;

    // Count cycles each side is held off with a request pending
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_i_wait <= 32'd0;
            r_perf_d_wait <= 32'd0;
        end else begin
            if (w_inst_pend && !i_req_ready) r_perf_i_wait <= r_perf_i_wait + 32'd1;
            if (w_data_pend && !d_req_ready) r_perf_d_wait <= r_perf_d_wait + 32'd1;
        end
    end

    assign perf_i_wait = r_perf_i_wait;
    assign perf_d_wait = r_perf_d_wait;
`else
    assign perf_i_wait = 32'd0;
    assign perf_d_wait = 32'd0;
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed self-checking bench for mem_port_arbiter. The bench
//            plays the memory; expected transactions are queued in grant
//            order and popped as the bus presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

`ifdef ARB_PERF_CNT_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_req_valid, i_req_ready, i_rvalid, i_rready;
    logic [31:0] i_rdata;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_read, d_write, d_req_ready, d_rvalid, d_rready;
    logic [3:0]  d_wstrb;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        m_read, m_write, m_req_ready, m_rvalid, m_rready;
    logic [3:0]  m_wstrb;
    logic [31:0] perf_i_wait, perf_d_wait;

    int checks = 0;
    int errors = 0;
    bit acc_i  = 1'b0;
    bit acc_d  = 1'b0;

    typedef struct {
        logic        wr;
        logic        src;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;
    txn_t q[$];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_req_valid(i_req_valid), .i_req_ready(i_req_ready),
        .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_req_ready(d_req_ready), .d_rdata(d_rdata),
        .d_rvalid(d_rvalid), .d_rready(d_rready),
        .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_req_ready(m_req_ready), .m_rdata(m_rdata),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .perf_i_wait(perf_i_wait), .perf_d_wait(perf_d_wait)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge and note any request acceptance
    task automatic samp();
        @(negedge clk);
        if (i_req_valid && i_req_ready) acc_i = 1'b1;
        if ((d_read || d_write) && d_req_ready) acc_d = 1'b1;
    endtask

    // Step past the rising edge and withdraw requests that were accepted
    task automatic adv();
        @(posedge clk);
        #1;
        if (acc_i) begin i_req_valid = 1'b0; acc_i = 1'b0; end
        if (acc_d) begin d_read = 1'b0; d_write = 1'b0; acc_d = 1'b0; end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk1({tag, "_m_read"},   m_read,   1'b0);
        chk1({tag, "_m_write"},  m_write,  1'b0);
        chk1({tag, "_m_rready"}, m_rready, 1'b0);
        chk1({tag, "_i_rvalid"}, i_rvalid, 1'b0);
        chk1({tag, "_d_rvalid"}, d_rvalid, 1'b0);
    endtask

    // Act as the memory for the next queued transaction
    task automatic serve(input int req_stall, input int rr_hold);
        txn_t t;
        int   n;
        bit   done;
        t = q.pop_front();
        n = 0;
        samp();
        while (!(m_read || m_write) && n < 20) begin adv(); samp(); n++; end
        chk1 ("bus_read",  m_read,  !t.wr);
        chk1 ("bus_write", m_write, t.wr);
        chk32("bus_addr",  m_addr,  t.addr);
        chk32("bus_wstrb", 32'(m_wstrb), 32'(t.strb));
        if (t.wr) chk32("bus_wdata", m_wdata, t.wdata);
        for (int k = 0; k < req_stall; k++) begin
            adv(); samp();
            chk32("stall_addr",  m_addr,  t.addr);
            chk1 ("stall_read",  m_read,  !t.wr);
            chk1 ("stall_write", m_write, t.wr);
            chk32("stall_wstrb", 32'(m_wstrb), 32'(t.strb));
        end
        m_req_ready = 1'b1;
        adv();
        m_req_ready = 1'b0;
        if (t.wr) begin
            samp();
            chk_idle_outputs("wr_done");
            adv();
        end else begin
            if (rr_hold > 0) begin
                if (t.src) d_rready = 1'b0; else i_rready = 1'b0;
            end
            m_rvalid = 1'b1;
            m_rdata  = t.rdata;
            done     = 1'b0;
            n        = 0;
            while (!done && n < 40) begin
                if (n >= rr_hold) begin i_rready = 1'b1; d_rready = 1'b1; end
                samp();
                chk1 ("resp_valid",  t.src ? d_rvalid : i_rvalid, 1'b1);
                chk1 ("resp_other",  t.src ? i_rvalid : d_rvalid, 1'b0);
                chk1 ("resp_rready", m_rready, t.src ? d_rready : i_rready);
                chk32("resp_data",   t.src ? d_rdata : i_rdata, t.rdata);
                if (m_rready) done = 1'b1;
                adv();
                n++;
            end
            chk1("resp_done", done, 1'b1);
            m_rvalid = 1'b0;
            m_rdata  = 32'h0;
            samp();
            chk1("resp_once", i_rvalid || d_rvalid, 1'b0);
            adv();
        end
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_addr = 32'h0; i_req_valid = 1'b0; i_rready = 1'b1;
        d_addr = 32'h0; d_read = 1'b0; d_write = 1'b0; d_wdata = 32'h0;
        d_wstrb = 4'h0; d_rready = 1'b1;
        m_req_ready = 1'b0; m_rdata = 32'h0; m_rvalid = 1'b0;

        // Reset state
        @(posedge clk); #1;
        samp();
        chk_idle_outputs("reset");
        chk1 ("reset_i_req_ready", i_req_ready, 1'b0);
        chk1 ("reset_d_req_ready", d_req_ready, 1'b0);
        chk32("reset_perf_i", perf_i_wait, 32'd0);
        chk32("reset_perf_d", perf_d_wait, 32'd0);
        adv();
        rst = 1'b0;

        // Conflict from reset: load wins, then fetch
        i_addr = 32'h0;  i_req_valid = 1'b1;
        d_addr = 32'h80; d_read = 1'b1;
        q.push_back('{wr:1'b0, src:1'b1, addr:32'h80, strb:4'h0, wdata:32'h0, rdata:32'hCAFE0080});
        q.push_back('{wr:1'b0, src:1'b0, addr:32'h0,  strb:4'h0, wdata:32'h0, rdata:32'h00000093});
        samp();
        chk1("c1_d_ready", d_req_ready, 1'b1);
        chk1("c1_i_ready", i_req_ready, 1'b0);
        adv();
        serve(0, 0);
        serve(0, 0);
        chk32("c1_perf_i", perf_i_wait, PERF ? 32'd3 : 32'd0);
        chk32("c1_perf_d", perf_d_wait, 32'd0);

        // Single fetch
        i_addr = 32'h100; i_req_valid = 1'b1;
        q.push_back('{wr:1'b0, src:1'b0, addr:32'h100, strb:4'h0, wdata:32'h0, rdata:32'h00000013});
        serve(0, 0);

        // Store, no response
        d_addr = 32'h204; d_write = 1'b1; d_wstrb = 4'b0100; d_wdata = 32'h00AB0000;
        q.push_back('{wr:1'b1, src:1'b1, addr:32'h204, strb:4'b0100, wdata:32'h00AB0000, rdata:32'h0});
        serve(0, 0);

        // Read and write together is taken as a write
        d_addr = 32'h208; d_read = 1'b1; d_write = 1'b1; d_wstrb = 4'hF; d_wdata = 32'h5555AAAA;
        q.push_back('{wr:1'b1, src:1'b1, addr:32'h208, strb:4'hF, wdata:32'h5555AAAA, rdata:32'h0});
        serve(0, 0);

        // Conflict after a data grant: fetch wins this time
        i_addr = 32'h40; i_req_valid = 1'b1;
        d_addr = 32'h44; d_read = 1'b1;
        q.push_back('{wr:1'b0, src:1'b0, addr:32'h40, strb:4'h0, wdata:32'h0, rdata:32'h11112222});
        q.push_back('{wr:1'b0, src:1'b1, addr:32'h44, strb:4'h0, wdata:32'h0, rdata:32'h33334444});
        samp();
        chk1("c2_i_ready", i_req_ready, 1'b1);
        chk1("c2_d_ready", d_req_ready, 1'b0);
        adv();
        serve(0, 0);
        serve(0, 0);
        chk32("c2_perf_i", perf_i_wait, PERF ? 32'd3 : 32'd0);
        chk32("c2_perf_d", perf_d_wait, PERF ? 32'd3 : 32'd0);

        // Backpressure on request and response
        i_addr = 32'h300; i_req_valid = 1'b1;
        q.push_back('{wr:1'b0, src:1'b0, addr:32'h300, strb:4'h0, wdata:32'h0, rdata:32'h1234ABCD});
        serve(5, 3);
        chk32("bp_perf_i", perf_i_wait, PERF ? 32'd3 : 32'd0);

        // Reset while waiting for read data
        i_addr = 32'h500; i_req_valid = 1'b1;
        samp();
        chk1("r5_i_ready", i_req_ready, 1'b1);
        adv();
        samp();
        chk1("r5_m_read", m_read, 1'b1);
        m_req_ready = 1'b1;
        adv();
        m_req_ready = 1'b0;
        samp();
        chk1("r5_in_resp", m_rready, 1'b1);
        rst = 1'b1;
        adv();
        rst = 1'b0;
        samp();
        chk_idle_outputs("r5_after");
        chk1 ("r5_after_i_req_ready", i_req_ready, 1'b0);
        chk1 ("r5_after_d_req_ready", d_req_ready, 1'b0);
        chk32("r5_after_perf_i", perf_i_wait, 32'd0);
        chk32("r5_after_perf_d", perf_d_wait, 32'd0);
        m_rvalid = 1'b1;
        m_rdata  = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            adv(); samp();
            chk1("r5_stray_i_rvalid", i_rvalid, 1'b0);
            chk1("r5_stray_d_rvalid", d_rvalid, 1'b0);
            chk1("r5_stray_m_rready", m_rready, 1'b0);
        end
        m_rvalid = 1'b0;
        adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire
